pq_sched: RTL

- Front-end scheduler that shares one priority queue among NREQ enqueue clients and one dequeue consumer.
- Round-robin arbitrates enqueue requests.
- Keeps a one-entry committed output slot filled with the minimum-key item, merging enqueue and dequeue into one PQ operation where legal.
- Supports a flush/drain sequence.
- Sits between client logic and any PQ implementation that follows the team PQ port contract (enq, deq, kvi, kvo, empty, full, busy).

---
 rtl/pq_pkg.sv | 24 ++
 rtl/pq_sched_chk.sv | 21 ++
 rtl/rr_arb.sv | 55 +++++
 rtl/pq_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue scheduler: item layout and FSM states.
package pq_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
    localparam int KV_WIDTH  = KEY_WIDTH + VAL_WIDTH;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // Strictly-smaller key wins; equal keys leave the PQ item in front.
    function automatic logic key_lt(input kv_t a, input kv_t b);
        return a.key < b.key;
    endfunction

endpackage

// File: rtl/pq_sched_chk.sv
// Consistency checks between the scheduler's occupancy count and PQ status.
module pq_sched_chk #(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH+1)
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic          pq_full,
    input logic          pq_empty
);

    a_full_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (count == CW'(DEPTH)) |-> pq_full)
        else $error("pq_sched_chk: count at DEPTH while pq_full is low");

    a_empty_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (count == '0) |-> pq_empty)
        else $error("pq_sched_chk: count zero while pq_empty is low");

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first request at or after the rotating
// pointer. The pointer moves past the grantee only when the caller reports
// an actual transfer through adv/grantee.
module rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    input  logic [IDXW-1:0] grantee,
    output logic [NREQ-1:0] gnt
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW:0]   sum_s;
    logic [IDXW-1:0] idx_s;
    logic            found_s;

    // Scan requests starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum_s = {1'b0, ptr_q} + (IDXW+1)'(off);
            if (sum_s >= (IDXW+1)'(NREQ)) begin
                sum_s = sum_s - (IDXW+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDXW-1:0];
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer advances to one past the grantee on a transfer, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= (grantee == IDXW'(NREQ-1)) ? '0 : grantee + IDXW'(1);
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/pq_sched.sv
// Front-end scheduler sharing one PQ among NREQ enqueue clients and one
// consumer. Keeps a committed one-entry output slot holding the minimum item,
// fusing enqueue+dequeue into one PQ operation where legal, with flush/drain.
// Optional: define PQ_SCHED_STATS_EN to add grant_cnt/stall_cnt counters.
module pq_sched
    import pq_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH+1),
    localparam int IDXW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef PQ_SCHED_STATS_EN
    output logic [NREQ*32-1:0]       grant_cnt,
    output logic [31:0]              stall_cnt,
`endif
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*KV_WIDTH-1:0] req_kv,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic [KV_WIDTH-1:0]      out_kv,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic                     flush_done,
    output logic [CW-1:0]            count,
    output logic                     pq_enq,
    output logic                     pq_deq,
    output logic [KV_WIDTH-1:0]      pq_kvi,
    input  logic [KV_WIDTH-1:0]      pq_kvo,
    input  logic                     pq_empty,
    input  logic                     pq_full,
    input  logic                     pq_busy
);

    sched_state_t    state_q;
    logic            flush_done_q;
    logic            out_valid_q, out_valid_d;
    kv_t             out_kv_q, out_kv_d;
    logic [CW-1:0]   count_q, count_d;

    logic [NREQ-1:0] gnt_raw_s, grant_s;
    logic [IDXW-1:0] grantee_s;
    kv_t             new_kv_s, head_kv_s;
    logic            run_s, slot_free_s, combo_ok_s, full_block_s, xfer_s;
    logic            enq_s, deq_s;

    assign run_s       = (state_q == RUN) && !pq_busy;
    assign head_kv_s   = kv_t'(pq_kvo);
    assign slot_free_s = !out_valid_q || out_ready;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid & {NREQ{run_s}}),
        .adv     (xfer_s),
        .grantee (grantee_s),
        .gnt     (gnt_raw_s)
    );

    // Select the candidate item and index of the raw grant.
    always_comb begin
        new_kv_s  = '0;
        grantee_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_raw_s[i]) begin
                new_kv_s  = kv_t'(req_kv[i*KV_WIDTH +: KV_WIDTH]);
                grantee_s = IDXW'(i);
            end else begin
                new_kv_s  = new_kv_s;
            end
        end
    end

    // A full PQ only accepts an item that rides along with a dequeue.
    assign combo_ok_s   = slot_free_s && !pq_empty && !key_lt(new_kv_s, head_kv_s);
    assign full_block_s = pq_full && !combo_ok_s;
    assign grant_s      = (full_block_s ? '0 : gnt_raw_s) & {NREQ{rst_n}};
    assign xfer_s       = |grant_s;

    // Per-cycle slot/PQ action; the first matching case wins.
    always_comb begin
        out_valid_d = out_valid_q;
        out_kv_d    = out_kv_q;
        count_d     = count_q;
        enq_s       = 1'b0;
        deq_s       = 1'b0;
        if (!pq_busy) begin
            if (slot_free_s && xfer_s && pq_empty) begin
                out_valid_d = 1'b1;
                out_kv_d    = new_kv_s;
            end else if (slot_free_s && xfer_s && key_lt(new_kv_s, head_kv_s)) begin
                out_valid_d = 1'b1;
                out_kv_d    = new_kv_s;
            end else if (slot_free_s && xfer_s) begin
                enq_s       = 1'b1;
                deq_s       = 1'b1;
                out_valid_d = 1'b1;
                out_kv_d    = head_kv_s;
            end else if (slot_free_s && !pq_empty) begin
                deq_s       = 1'b1;
                out_valid_d = 1'b1;
                out_kv_d    = head_kv_s;
                count_d     = (count_q != '0) ? count_q - CW'(1) : count_q;
            end else if (!slot_free_s && xfer_s) begin
                enq_s   = 1'b1;
                count_d = (count_q != CW'(DEPTH)) ? count_q + CW'(1) : count_q;
            end else if (slot_free_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else if (slot_free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output slot and occupancy count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_kv_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_kv_q    <= out_kv_d;
            count_q     <= count_d;
        end
    end

    // Flush FSM with registered completion pulse (high only in DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    state_q      <= flush ? FLUSH : RUN;
                    flush_done_q <= 1'b0;
                end
                FLUSH: begin
                    if (pq_empty && (count_q == '0) && !out_valid_q) begin
                        state_q      <= DONE;
                        flush_done_q <= 1'b1;
                    end else begin
                        state_q      <= FLUSH;
                        flush_done_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q      <= RUN;
                    flush_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= RUN;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = grant_s;
    assign out_valid  = out_valid_q;
    assign out_kv     = out_kv_q;
    assign count      = count_q;
    assign flush_done = flush_done_q;
    assign pq_enq     = enq_s & rst_n;
    assign pq_deq     = deq_s & rst_n;
    assign pq_kvi     = (enq_s && rst_n) ? new_kv_s : '0;

`ifdef PQ_SCHED_STATS_EN
    logic [NREQ-1:0][31:0] grant_cnt_q;
    logic [31:0]           stall_cnt_q;

    // Wrapping per-client transfer counters and stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= grant_s[i] ? grant_cnt_q[i] + 32'd1 : grant_cnt_q[i];
            end
            stall_cnt_q <= ((|req_valid) && !xfer_s) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
